// File: rtl/gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gate_arbiter
// Description : Arbitrates entry/exit gate requests into the parking FSM.
//               Screens the winning request against FSM status, issues a
//               one-cycle entry/exit pulse with an ack, or a one-cycle reject,
//               then holds the gate for GATE_CYCLES cycles so only one FSM
//               event is in flight at a time.
//               Optional build macro: EXIT_PRIORITY_EN (exit always wins
//               a simultaneous request instead of round-robin tie-break).
// Revision    : 1.0 - initial release
// ============================================================================
module gate_arbiter #(
    parameter int GATE_CYCLES = 4,
    parameter int SLOTS       = 4,
    localparam int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              entry_req,
    input  logic              exit_req,
    input  logic [SLOT_W-1:0] exit_slot_req,
    input  logic              is_full,
    input  logic [SLOTS-1:0]  spots,
    output logic              entry_signal,
    output logic              exit_signal,
    output logic [SLOT_W-1:0] exit_slot,
    output logic              entry_ack,
    output logic              exit_ack,
    output logic              entry_reject,
    output logic              exit_reject,
    output logic              gate_busy,
    output logic              last_grant
);

    localparam int c_cnt_w = $clog2(GATE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_hold_init = c_cnt_w'(GATE_CYCLES - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_issue  = 2'd1;
    localparam logic [1:0] c_st_hold   = 2'd2;
    localparam logic [1:0] c_st_reject = 2'd3;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;

    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_any_req;
    logic               w_pick_exit;
    logic               w_decide;
    logic               w_go;
    logic               w_rej;
    logic               w_slot_occ;

    // Winner selection: a lone request wins; ties go round-robin (or exit-first)
    always_comb begin
        w_any_req  = entry_req | exit_req;
        w_slot_occ = spots[exit_slot_req];
`ifdef EXIT_PRIORITY_EN
        w_pick_exit = exit_req;
`else
        // On a tie the winner is the opposite of the previous decision
        w_pick_exit = exit_req & (~entry_req | ~last_grant);
`endif
    end

    // Next-state, hold counter and decision outcome
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_decide    = 1'b0;
        w_go        = 1'b0;
        w_rej       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_any_req) begin
                    w_decide = 1'b1;
                    // FSM status is only looked at here, never during HOLD
                    if (w_pick_exit ? ~w_slot_occ : is_full) begin
                        w_rej       = 1'b1;
                        w_state_nxt = c_st_reject;
                    end else begin
                        w_go        = 1'b1;
                        w_state_nxt = c_st_issue;
                    end
                end
            end
            c_st_issue: begin
                w_state_nxt = c_st_hold;
                w_cnt_nxt   = c_hold_init;
            end
            c_st_hold: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            c_st_reject: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register and registered outputs; pulses are set on the decision edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            entry_signal <= 1'b0;
            exit_signal  <= 1'b0;
            exit_slot    <= '0;
            entry_ack    <= 1'b0;
            exit_ack     <= 1'b0;
            entry_reject <= 1'b0;
            exit_reject  <= 1'b0;
            gate_busy    <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            entry_signal <= w_go & ~w_pick_exit;
            entry_ack    <= w_go & ~w_pick_exit;
            exit_signal  <= w_go & w_pick_exit;
            exit_ack     <= w_go & w_pick_exit;
            entry_reject <= w_rej & ~w_pick_exit;
            exit_reject  <= w_rej & w_pick_exit;
            gate_busy    <= (w_state_nxt == c_st_issue) || (w_state_nxt == c_st_hold);
            if (w_decide) begin
                last_grant <= w_pick_exit;
            end
            // Slot index stays stable from ISSUE until the next grant
            if (w_go) begin
                exit_slot <= exit_slot_req;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_arbiter
// Description : Directed self-checking bench for gate_arbiter (GATE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_arbiter;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic [1:0] exit_slot_req;
    logic       is_full;
    logic [3:0] spots;
    logic       entry_signal;
    logic       exit_signal;
    logic [1:0] exit_slot;
    logic       entry_ack;
    logic       exit_ack;
    logic       entry_reject;
    logic       exit_reject;
    logic       gate_busy;
    logic       last_grant;

    int n_tests = 0;
    int n_fail  = 0;

    gate_arbiter #(
        .GATE_CYCLES (4),
        .SLOTS       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .exit_req      (exit_req),
        .exit_slot_req (exit_slot_req),
        .is_full       (is_full),
        .spots         (spots),
        .entry_signal  (entry_signal),
        .exit_signal   (exit_signal),
        .exit_slot     (exit_slot),
        .entry_ack     (entry_ack),
        .exit_ack      (exit_ack),
        .entry_reject  (entry_reject),
        .exit_reject   (exit_reject),
        .gate_busy     (gate_busy),
        .last_grant    (last_grant)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed view of all outputs: {sig_e, sig_x, slot[1:0], ack_e, ack_x, rej_e, rej_x, busy, last}
    function automatic logic [9:0] outs();
        return {entry_signal, exit_signal, exit_slot, entry_ack, exit_ack,
                entry_reject, exit_reject, gate_busy, last_grant};
    endfunction

    int busy_cnt;
    int sig_cnt;
    int ack_cnt;
    int t_e1;
    int t_e2;
    int t_x1;
    int reraise_at;

    initial begin
        reset         = 1'b0;
        entry_req     = 1'b0;
        exit_req      = 1'b0;
        exit_slot_req = 2'b00;
        is_full       = 1'b0;
        spots         = 4'b0000;

        // Reset for two cycles
        step();
        step();
        chk("reset_outputs", {22'd0, outs()}, {22'd0, 10'b00_0000_0001});
        chk("reset_last_grant", last_grant, 1'b1);

        // Entry granted with lot not full
        reset     = 1'b1;
        entry_req = 1'b1;
        busy_cnt  = 0;
        sig_cnt   = 0;
        ack_cnt   = 0;
        step();
        chk("entry_first_cycle", {entry_signal, entry_ack, gate_busy}, 3'b111);
        chk("entry_last_grant", last_grant, 1'b0);
        entry_req = 1'b0;
        busy_cnt += gate_busy ? 1 : 0;
        sig_cnt  += entry_signal ? 1 : 0;
        ack_cnt  += entry_ack ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            step();
            busy_cnt += gate_busy ? 1 : 0;
            sig_cnt  += entry_signal ? 1 : 0;
            ack_cnt  += entry_ack ? 1 : 0;
        end
        chk("entry_busy_cycles", busy_cnt, 5);
        chk("entry_signal_cycles", sig_cnt, 1);
        chk("entry_ack_cycles", ack_cnt, 1);

        // Entry rejected when full
        is_full   = 1'b1;
        entry_req = 1'b1;
        step();
        chk("entry_reject_pulse", {entry_reject, entry_signal, entry_ack, gate_busy}, 4'b1000);
        entry_req = 1'b0;
        step();
        chk("entry_reject_one_cycle", {entry_reject, entry_signal, gate_busy}, 3'b000);
        step();
        is_full = 1'b0;

        // Exit granted from an occupied slot
        spots         = 4'b0111;
        exit_req      = 1'b1;
        exit_slot_req = 2'b10;
        step();
        chk("exit_grant", {exit_signal, exit_ack, exit_slot, last_grant}, 5'b11_10_1);
        exit_req      = 1'b0;
        exit_slot_req = 2'b00;
        for (int i = 0; i < 5; i++) step();
        chk("exit_slot_held", exit_slot, 2'b10);

        // Exit rejected from an empty slot
        exit_req      = 1'b1;
        exit_slot_req = 2'b11;
        step();
        chk("exit_reject", {exit_reject, exit_signal, exit_ack, gate_busy}, 4'b1000);
        chk("exit_slot_after_reject", exit_slot, 2'b10);
        exit_req = 1'b0;
        step();
        step();

        // Simultaneous requests after reset: round-robin ordering
        reset = 1'b0;
        step();
        reset         = 1'b1;
        spots         = 4'b0111;
        exit_slot_req = 2'b00;
        entry_req     = 1'b1;
        exit_req      = 1'b1;
        t_e1          = -1;
        t_e2          = -1;
        t_x1          = -1;
        reraise_at    = -1;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (entry_ack) begin
                entry_req = 1'b0;
                if (t_e1 < 0) begin
                    t_e1       = i;
                    reraise_at = i + 1;
                end else if (t_e2 < 0) begin
                    t_e2 = i;
                end
            end
            if (exit_ack) begin
                exit_req = 1'b0;
                if (t_x1 < 0) t_x1 = i;
            end
            if (i == reraise_at) entry_req = 1'b1;
        end
`ifdef EXIT_PRIORITY_EN
        chk("tie_exit_time", t_x1, 1);
        chk("tie_entry_time", t_e1, 7);
`else
        chk("tie_entry_time", t_e1, 1);
        chk("tie_exit_time", t_x1, 7);
`endif
        chk("tie_entry2_time", t_e2, 13);
        for (int i = 0; i < 8; i++) step();

        // Reset asserted in the second HOLD cycle, request left held
        entry_req = 1'b1;
        step();
        chk("pre_reset_issue", {entry_ack, gate_busy}, 2'b11);
        step();
        step();
        chk("pre_reset_hold_busy", {entry_ack, gate_busy}, 2'b01);
        reset = 1'b0;
        step();
        chk("mid_reset_outputs", {22'd0, outs()}, {22'd0, 10'b00_0000_0001});
        reset = 1'b1;
        step();
        chk("post_reset_grant", {entry_signal, entry_ack, gate_busy, last_grant}, 4'b1110);
        entry_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("post_reset_idle", gate_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
